// File: rtl/warp_instr_fifo.sv
// warp_instr_fifo: per-warp DEPTH-entry decoded-instruction FIFOs with flush; define INSTR_FIFO_ERR_EN for sticky overflow/underflow flags
module warp_instr_fifo #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int OPC_W     = 4,
  parameter int REG_W     = 4,
  parameter int IMM_W     = 4,
  parameter int ARR_W     = 2,
  parameter int WARP_W    = $clog2(NUM_WARPS),
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [WARP_W-1:0]    wr_warp,
  input  logic [OPC_W-1:0]     opcode_in,
  input  logic [REG_W-1:0]     target_reg_in,
  input  logic [REG_W-1:0]     address_reg_in,
  input  logic [IMM_W-1:0]     imm_short_in,
  input  logic [ARR_W-1:0]     array_id_in,
  output logic [NUM_WARPS-1:0] wr_ready,
  input  logic                 issue_en,
  input  logic [WARP_W-1:0]    issue_warp,
  input  logic [NUM_WARPS-1:0] flush,
  output logic [NUM_WARPS-1:0] head_valid,
  output logic [OPC_W-1:0]     opcode_out      [NUM_WARPS],
  output logic [REG_W-1:0]     target_reg_out  [NUM_WARPS],
  output logic [REG_W-1:0]     address_reg_out [NUM_WARPS],
  output logic [IMM_W-1:0]     imm_short_out   [NUM_WARPS],
  output logic [ARR_W-1:0]     array_id_out    [NUM_WARPS],
  output logic [CNT_W-1:0]     count           [NUM_WARPS]
`ifdef INSTR_FIFO_ERR_EN
  ,
  output logic [NUM_WARPS-1:0] err_overflow,
  output logic [NUM_WARPS-1:0] err_underflow
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = OPC_W + 2 * REG_W + IMM_W + ARR_W;
  logic [ENT_W-1:0] wdata;
  assign wdata = {opcode_in, target_reg_in, address_reg_in, imm_short_in, array_id_in};
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic sel_wr, sel_rd, push, pop;
    assign sel_wr = wr_valid && (wr_warp == WARP_W'(w));
    assign sel_rd = issue_en && (issue_warp == WARP_W'(w));
    // ready/valid come only from registered count, so a same-cycle pop never unblocks a push to a full warp
    assign wr_ready[w]   = cnt != CNT_W'(DEPTH);
    assign head_valid[w] = cnt != '0;
    assign push = sel_wr && wr_ready[w];
    assign pop  = sel_rd && head_valid[w];
    assign count[w] = cnt;
    assign {opcode_out[w], target_reg_out[w], address_reg_out[w], imm_short_out[w], array_id_out[w]} = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
      end else if (flush[w]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) mem[wr_ptr] <= wdata;
        wr_ptr <= wr_ptr + PTR_W'(push);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        cnt    <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
`ifdef INSTR_FIFO_ERR_EN
    logic ovf, unf;
    assign err_overflow[w]  = ovf;
    assign err_underflow[w] = unf;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else if (flush[w]) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        ovf <= ovf || (sel_wr && !wr_ready[w]);
        unf <= unf || (sel_rd && !head_valid[w]);
      end
`endif
  end
endmodule

// File: tb/tb_warp_instr_fifo.sv
// tb_warp_instr_fifo: directed stimulus with a pop scoreboard checked by a negedge monitor thread
module tb_warp_instr_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_warp = '0;
  logic [3:0] opcode_in = '0, target_reg_in = '0, address_reg_in = '0, imm_short_in = '0;
  logic [1:0] array_id_in = '0;
  logic [3:0] wr_ready;
  logic       issue_en = 1'b0;
  logic [1:0] issue_warp = '0;
  logic [3:0] flush = '0;
  logic [3:0] head_valid;
  logic [3:0] opcode_out [4];
  logic [3:0] target_reg_out [4];
  logic [3:0] address_reg_out [4];
  logic [3:0] imm_short_out [4];
  logic [1:0] array_id_out [4];
  logic [2:0] count [4];
`ifdef INSTR_FIFO_ERR_EN
  logic [3:0] err_overflow, err_underflow;
`endif
  int checks = 0;
  int errors = 0;
  logic [17:0] sb [$];

  warp_instr_fifo dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_warp(wr_warp),
    .opcode_in(opcode_in), .target_reg_in(target_reg_in), .address_reg_in(address_reg_in),
    .imm_short_in(imm_short_in), .array_id_in(array_id_in), .wr_ready(wr_ready),
    .issue_en(issue_en), .issue_warp(issue_warp), .flush(flush), .head_valid(head_valid),
    .opcode_out(opcode_out), .target_reg_out(target_reg_out), .address_reg_out(address_reg_out),
    .imm_short_out(imm_short_out), .array_id_out(array_id_out), .count(count)
`ifdef INSTR_FIFO_ERR_EN
    , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ent(input logic [3:0] op);
    logic [3:0] a = op + 4'd3;
    return {op, op ^ 4'h5, ~op, a, op[1:0]};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] pw, input logic [3:0] op,
                       input logic iv, input logic [1:0] iw, input logic ep,
                       input logic [3:0] eop, input logic [3:0] fl);
    logic [17:0] e = ent(op);
    {opcode_in, target_reg_in, address_reg_in, imm_short_in, array_id_in} = e;
    wr_valid = pv; wr_warp = pw; issue_en = iv; issue_warp = iw; flush = fl;
    if (ep) sb.push_back(ent(eop));
    @(posedge clk); #1;
    wr_valid = 1'b0; issue_en = 1'b0; flush = '0;
  endtask

  task automatic push(input logic [1:0] w, input logic [3:0] op);
    drive(1'b1, w, op, 1'b0, 2'd0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic pop(input logic [1:0] w, input logic [3:0] eop);
    drive(1'b0, 2'd0, 4'd0, 1'b1, w, 1'b1, eop, 4'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_head_valid"}, int'(head_valid), 0);
    check({tag, "_wr_ready"}, int'(wr_ready), 4'hf);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_count%0d", tag, i), int'(count[i]), 0);
      check($sformatf("%s_head%0d", tag, i),
            int'({opcode_out[i], target_reg_out[i], address_reg_out[i], imm_short_out[i], array_id_out[i]}), 0);
    end
`ifdef INSTR_FIFO_ERR_EN
    check({tag, "_err"}, int'({err_overflow, err_underflow}), 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : stim
        logic [3:0] op, eop;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_idle("reset");
        for (int i = 1; i <= 4; i++) push(2'd2, 4'(i));
        check("w2_count_full", int'(count[2]), 4);
        check("w2_wr_ready", int'(wr_ready), 4'b1011);
        check("w2_head_valid", int'(head_valid), 4'b0100);
        check("w2_head_op", int'(opcode_out[2]), 1);
        for (int i = 1; i <= 4; i++) pop(2'd2, 4'(i));
        check("w2_drained_valid", int'(head_valid[2]), 0);
        check("w2_drained_count", int'(count[2]), 0);
        for (int i = 5; i <= 8; i++) push(2'd0, 4'(i));
        push(2'd0, 4'd9);
        check("w0_overflow_count", int'(count[0]), 4);
        check("w0_overflow_head", int'(opcode_out[0]), 5);
        drive(1'b1, 2'd0, 4'd10, 1'b1, 2'd0, 1'b1, 4'd5, 4'd0);
        check("w0_full_pushpop_count", int'(count[0]), 3);
        check("w0_full_pushpop_ready", int'(wr_ready[0]), 1);
        pop(2'd0, 4'd6);
        pop(2'd0, 4'd7);
        check("w0_count_one", int'(count[0]), 1);
        drive(1'b1, 2'd1, 4'd11, 1'b1, 2'd1, 1'b0, 4'd0, 4'd0);
        check("w1_empty_pushpop_count", int'(count[1]), 1);
        check("w1_empty_pushpop_head", int'(opcode_out[1]), 11);
`ifdef INSTR_FIFO_ERR_EN
        check("err_overflow", int'(err_overflow), 4'b0001);
        check("err_underflow", int'(err_underflow), 4'b0010);
`endif
        push(2'd1, 4'd12);
        drive(1'b1, 2'd1, 4'd13, 1'b1, 2'd1, 1'b1, 4'd11, 4'd0);
        check("w1_pushpop_count", int'(count[1]), 2);
        check("w1_pushpop_head", int'(opcode_out[1]), 12);
        for (int i = 0; i < 5; i++) begin
          op = 4'd14 + 4'(i);
          eop = 4'd12 + 4'(i);
          push(2'd1, op);
          pop(2'd1, eop);
        end
        check("w1_wrap_count", int'(count[1]), 2);
        check("w1_wrap_head", int'(opcode_out[1]), 1);
        push(2'd3, 4'd3);
        push(2'd3, 4'd5);
        push(2'd3, 4'd7);
        check("w3_count_three", int'(count[3]), 3);
        drive(1'b1, 2'd3, 4'd9, 1'b0, 2'd0, 1'b0, 4'd0, 4'b1000);
        check("flush_w3_count", int'(count[3]), 0);
        check("flush_w3_valid", int'(head_valid[3]), 0);
        check("flush_w0_count", int'(count[0]), 1);
        check("flush_w0_head", int'(opcode_out[0]), 8);
        check("flush_w1_count", int'(count[1]), 2);
        push(2'd3, 4'd6);
        check("w3_after_flush_head", int'(opcode_out[3]), 6);
        check("w3_after_flush_count", int'(count[3]), 1);
`ifdef INSTR_FIFO_ERR_EN
        drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 4'd0, 4'b0001);
        check("flush_clears_err", int'({err_overflow, err_underflow}), 8'b0000_0010);
        push(2'd0, 4'd8);
`endif
        #1 reset = 1'b0;
        #1;
        check_idle("async");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");
      end
      forever begin
        logic [17:0] got, exp;
        @(negedge clk);
        if (reset && issue_en && head_valid[issue_warp]) begin
          got = {opcode_out[issue_warp], target_reg_out[issue_warp], address_reg_out[issue_warp],
                 imm_short_out[issue_warp], array_id_out[issue_warp]};
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected warp %0d: got %h, required no pop", issue_warp, got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL pop_head warp %0d: got %h, required %h", issue_warp, got, exp);
            end
          end
        end
      end
    join_any
    disable fork;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
